bram_stream_reader: RTL and testbench
=====================================

BRAM_STREAM_READER -- requirements
Module: bram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 20, memory word width.
REQ-002 SHALL have parameter DEPTH, default 13264, memory word count.
REQ-003 SHALL have parameter CLK_LATENCY, default 1, memory read latency in cycles; legal values 0, 1 and 2.
REQ-004 SHALL have parameter DATA_ADDR_W, default $clog2(DEPTH), address width.
REQ-005 SHALL have port clk, input, 1, single clock; all logic is on the rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-007 SHALL have port start, input, 1, request to begin a burst read.
REQ-008 SHALL have port base_addr, input, DATA_ADDR_W, first word address; sampled when start is accepted.
REQ-009 SHALL have port length, input, DATA_ADDR_W+1, word count (0..DEPTH); sampled when start is accepted.
REQ-010 SHALL have port addrb, output, DATA_ADDR_W, registered read address to the memory.
REQ-011 SHALL have port dout, input, DATA_WIDTH, read data from the memory.
REQ-012 SHALL have port m_data, output, DATA_WIDTH, stream data.
REQ-013 SHALL have port m_valid, output, 1, stream valid.
REQ-014 SHALL have port m_ready, input, 1, stream ready from the consumer.
REQ-015 SHALL have port m_last, output, 1, marks the final beat of a burst.
REQ-016 SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-017 SHALL have port done, output, 1, one-cycle pulse when a burst completes.

Function
REQ-018 SHALL implement state machine IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
REQ-019 SHALL accept start only in IDLE; start in any other state SHALL be ignored.
REQ-020 SHALL go IDLE -> DONE on a start with length==0, issue no reads and assert no m_valid.
REQ-021 SHALL go to FETCH on a start with length!=0.
REQ-022 SHALL, in FETCH, issue one read per cycle when credit is available, by updating addrb and tagging the issue.
REQ-023 SHALL time each read as follows: dout is valid CLK_LATENCY cycles after addrb changes, or the same cycle when CLK_LATENCY is 0.
REQ-024 SHALL carry the issue tag through a CLK_LATENCY-deep valid pipeline and capture dout into the skid FIFO only when the tag emerges.
REQ-025 SHALL size the skid FIFO at CLK_LATENCY+2 entries.
REQ-026 SHALL issue a read only if (reads in flight + FIFO occupancy) < FIFO depth, so the FIFO never overflows.
REQ-027 SHALL wrap the address from DEPTH-1 to 0.
REQ-028 SHALL go FETCH -> DRAIN once length reads have been issued.
REQ-029 SHALL go DRAIN -> DONE on the cycle the final beat handshakes (m_valid & m_ready & m_last).
REQ-030 SHALL hold done high for exactly one cycle while in DONE, then return to IDLE.
REQ-031 SHALL present m_data from the FIFO head, with m_valid = FIFO not empty.
REQ-032 SHALL hold m_data and m_last stable while m_valid & !m_ready.
REQ-033 SHALL assert m_last only on the length-th beat.
REQ-034 SHALL sustain 1 beat per cycle when m_ready is held high, after an initial fill of CLK_LATENCY+1 cycles from start.
REQ-035 SHALL allow a FIFO push and pop in the same cycle, leaving occupancy unchanged.
REQ-036 SHALL accept a start in the cycle immediately after DONE.
REQ-037 SHALL deliver beats in address order with no duplicate or lost beats under any m_ready pattern.

Reset
REQ-038 SHALL, with rst_n low at a clock edge, set the state to IDLE and drive addrb=0, m_data=0, m_valid=0, m_last=0, busy=0, done=0.
REQ-039 SHALL, on reset, empty the FIFO, clear the tag pipeline and zero the counters.
REQ-040 SHALL, on reset mid-burst, abandon the burst: m_valid is 0 from the next cycle, no done pulse, and in-flight returns are discarded.

Verification (memory preloaded with mem[i]=i, CLK_LATENCY=1 unless stated)
REQ-041 SHALL cover: base_addr=5, length=4, m_ready=1 -> beats 5,6,7,8 on consecutive cycles, m_last with 8, done one cycle later.
REQ-042 SHALL cover: base_addr=13262, length=4 -> beats 13262, 13263, 0, 1; m_last with 1.
REQ-043 SHALL cover: length=8, m_ready toggling 1,0,1,0 -> exactly beats 0..7, data stable while stalled, no FIFO overflow.
REQ-044 SHALL cover: length=0 -> done the cycle after start, m_valid never asserted, busy high for 1 cycle.
REQ-045 SHALL cover: rst_n low after 3 of 10 beats -> m_valid=0 and busy=0 next cycle, no done; a new start with length=2 gives beats base, base+1.
REQ-046 SHALL cover: REQ-041 repeated with CLK_LATENCY=0 and CLK_LATENCY=2 -> identical beat sequence, first beat at start+1 and start+3 respectively.

Source files
------------

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Reads a burst of consecutive words from a block RAM and presents them as a
// valid/ready stream. Reads are issued ahead of the consumer, tracked through a
// tag pipeline matching the memory latency, and landed in a small skid FIFO.
// A credit check keeps the FIFO from ever overflowing.
//
// Ports:
//   clk        - clock, all logic on the rising edge
//   rst_n      - synchronous active-low reset
//   start      - begin a burst (accepted only while idle)
//   base_addr  - first word address, sampled with start
//   length     - number of words (0..DEPTH), sampled with start
//   addrb      - registered read address to the memory
//   dout       - read data from the memory
//   m_data     - stream data (FIFO head)
//   m_valid    - stream valid (FIFO not empty)
//   m_ready    - stream ready from the consumer
//   m_last     - final beat of the burst
//   busy       - high whenever the controller is not idle
//   done       - one-cycle pulse when a burst completes
module bram_stream_reader #(
  parameter int DATA_WIDTH  = 20,
  parameter int DEPTH       = 13264,
  parameter int CLK_LATENCY = 1,
  parameter int DATA_ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [DATA_ADDR_W-1:0] base_addr,
  input  logic [DATA_ADDR_W:0]   length,
  output logic [DATA_ADDR_W-1:0] addrb,
  input  logic [DATA_WIDTH-1:0]  dout,
  output logic [DATA_WIDTH-1:0]  m_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_last,
  output logic                   busy,
  output logic                   done
);

  localparam int FIFO_DEPTH = CLK_LATENCY + 2;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state_r;
  logic [DATA_ADDR_W-1:0] addrb_r;
  logic [DATA_ADDR_W-1:0] next_addr_r;
  logic [DATA_ADDR_W:0]   remaining_r;
  logic                   busy_r;
  logic                   done_r;

  logic                   tag_vld_r  [0:CLK_LATENCY];
  logic                   tag_last_r [0:CLK_LATENCY];

  logic [DATA_WIDTH-1:0]  fifo_data_r [0:FIFO_DEPTH-1];
  logic                   fifo_last_r [0:FIFO_DEPTH-1];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic [CNT_W-1:0]       inflight_r;

  logic                   pop_s;
  logic                   push_s;
  logic                   credit_s;
  logic                   start_ok_s;
  logic                   issue_s;
  logic [DATA_ADDR_W-1:0] issue_addr_s;
  logic                   issue_last_s;
  logic                   final_hs_s;
  logic [CNT_W:0]         commit_s;
  logic [CNT_W:0]         limit_s;

  // Address increment with wrap from DEPTH-1 back to 0.
  function automatic logic [DATA_ADDR_W-1:0] addr_inc(input logic [DATA_ADDR_W-1:0] a);
    if (a == DATA_ADDR_W'(DEPTH - 1)) begin
      addr_inc = '0;
    end else begin
      addr_inc = a + DATA_ADDR_W'(1);
    end
  endfunction

  // FIFO pointer increment; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign pop_s      = (count_r != '0) && m_ready;
  assign push_s     = tag_vld_r[CLK_LATENCY];
  assign final_hs_s = pop_s && fifo_last_r[rd_ptr_r];

  // Credit: reads in flight plus entries that will still be held after this
  // cycle's pop must leave room for one more read.
  assign commit_s = {1'b0, inflight_r} + {1'b0, count_r};
  assign limit_s  = (CNT_W + 1)'(FIFO_DEPTH) + {{CNT_W{1'b0}}, pop_s};
  assign credit_s = commit_s < limit_s;

  // The first read of a burst is issued on the accepting edge itself so the
  // first beat appears CLK_LATENCY+1 cycles after start.
  assign start_ok_s   = (state_r == IDLE) && start && (length != '0);
  assign issue_s      = start_ok_s ||
                        ((state_r == FETCH) && (remaining_r != '0) && credit_s);
  assign issue_addr_s = start_ok_s ? base_addr : next_addr_r;
  assign issue_last_s = start_ok_s ? (length == (DATA_ADDR_W + 1)'(1))
                                   : (remaining_r == (DATA_ADDR_W + 1)'(1));

  // Control FSM, read address generation and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      addrb_r     <= '0;
      next_addr_r <= '0;
      remaining_r <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      if (issue_s) begin
        addrb_r     <= issue_addr_s;
        next_addr_r <= addr_inc(issue_addr_s);
      end
      if (start_ok_s) begin
        remaining_r <= length - (DATA_ADDR_W + 1)'(1);
      end else if (issue_s) begin
        remaining_r <= remaining_r - (DATA_ADDR_W + 1)'(1);
      end
      case (state_r)
        IDLE: begin
          if (start) begin
            busy_r <= 1'b1;
            if (length == '0) begin
              state_r <= DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= FETCH;
              done_r  <= 1'b0;
            end
          end else begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
        end
        FETCH: begin
          busy_r <= 1'b1;
          done_r <= 1'b0;
          if ((remaining_r == '0) ||
              (issue_s && (remaining_r == (DATA_ADDR_W + 1)'(1)))) begin
            state_r <= DRAIN;
          end
        end
        DRAIN: begin
          busy_r <= 1'b1;
          if (final_hs_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else begin
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  // Issue-tag pipeline; a tag leaving the last stage marks valid read data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= CLK_LATENCY; i++) begin
        tag_vld_r[i]  <= 1'b0;
        tag_last_r[i] <= 1'b0;
      end
    end else begin
      tag_vld_r[0]  <= issue_s;
      tag_last_r[0] <= issue_s && issue_last_s;
      for (int i = 1; i <= CLK_LATENCY; i++) begin
        tag_vld_r[i]  <= tag_vld_r[i-1];
        tag_last_r[i] <= tag_last_r[i-1];
      end
    end
  end

  // Skid FIFO storage, pointers, occupancy and in-flight read counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_data_r[i] <= '0;
        fifo_last_r[i] <= 1'b0;
      end
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      inflight_r <= '0;
    end else begin
      if (push_s) begin
        fifo_data_r[wr_ptr_r] <= dout;
        fifo_last_r[wr_ptr_r] <= tag_last_r[CLK_LATENCY];
        wr_ptr_r              <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      case ({issue_s, push_s})
        2'b10:   inflight_r <= inflight_r + CNT_W'(1);
        2'b01:   inflight_r <= inflight_r - CNT_W'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  assign addrb   = addrb_r;
  assign m_valid = (count_r != '0);
  assign m_data  = fifo_data_r[rd_ptr_r];
  assign m_last  = m_valid && fifo_last_r[rd_ptr_r];
  assign busy    = busy_r;
  assign done    = done_r;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Testbench for bram_stream_reader: three instances (CLK_LATENCY 0, 1, 2)
// share stimulus; each has its own memory model (mem[i]=i), expected-beat
// queue and monitor.
module tb_bram_stream_reader;

  localparam int DW    = 20;
  localparam int DEPTH = 13264;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          m_ready;

  logic [AW-1:0] addrb_a   [3];
  logic [DW-1:0] dout_a    [3];
  logic [DW-1:0] m_data_a  [3];
  logic          m_valid_a [3];
  logic          m_last_a  [3];
  logic          busy_a    [3];
  logic          done_a    [3];

  logic [DW-1:0] l1_q;
  logic [DW-1:0] l2_q1;
  logic [DW-1:0] l2_q2;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [DW:0] exp_q [3][$];
  int first_cyc  [3];
  int last_cyc   [3];
  int done_cyc   [3];
  int done_cnt   [3];
  int busy_cnt   [3];
  int beats_seen [3];
  logic          prev_stall [3];
  logic [DW-1:0] prev_data  [3];
  logic          prev_last  [3];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory models: combinational, one-register and two-register reads.
  assign dout_a[0] = DW'(addrb_a[0]);
  always @(posedge clk) l1_q <= DW'(addrb_a[1]);
  assign dout_a[1] = l1_q;
  always @(posedge clk) begin
    l2_q1 <= DW'(addrb_a[2]);
    l2_q2 <= l2_q1;
  end
  assign dout_a[2] = l2_q2;

  bram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CLK_LATENCY(0)) u_l0 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .addrb(addrb_a[0]), .dout(dout_a[0]), .m_data(m_data_a[0]), .m_valid(m_valid_a[0]),
    .m_ready(m_ready), .m_last(m_last_a[0]), .busy(busy_a[0]), .done(done_a[0]));
  bram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CLK_LATENCY(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .addrb(addrb_a[1]), .dout(dout_a[1]), .m_data(m_data_a[1]), .m_valid(m_valid_a[1]),
    .m_ready(m_ready), .m_last(m_last_a[1]), .busy(busy_a[1]), .done(done_a[1]));
  bram_stream_reader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CLK_LATENCY(2)) u_l2 (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
    .addrb(addrb_a[2]), .dout(dout_a[2]), .m_data(m_data_a[2]), .m_valid(m_valid_a[2]),
    .m_ready(m_ready), .m_last(m_last_a[2]), .busy(busy_a[2]), .done(done_a[2]));

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [lat%0d]: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  // Monitor: stall stability, beat scoreboard and status bookkeeping.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      for (int i = 0; i < 3; i++) begin
        if (busy_a[i]) busy_cnt[i]++;
        if (done_a[i]) begin
          done_cnt[i]++;
          done_cyc[i] = cyc;
        end
        if (prev_stall[i]) begin
          check("stall_valid", i, 32'(m_valid_a[i]), 32'd1);
          check("stall_data", i, 32'(m_data_a[i]), 32'(prev_data[i]));
          check("stall_last", i, 32'(m_last_a[i]), 32'(prev_last[i]));
        end
        prev_stall[i] = m_valid_a[i] && !m_ready;
        prev_data[i]  = m_data_a[i];
        prev_last[i]  = m_last_a[i];
        if (m_valid_a[i]) begin
          if (first_cyc[i] < 0) first_cyc[i] = cyc;
          if (m_ready) begin
            if (exp_q[i].size() == 0) begin
              check("unexpected_beat", i, 32'(m_data_a[i]), 32'hFFFFFFFF);
            end else begin
              logic [DW:0] e;
              e = exp_q[i].pop_front();
              check("beat_data", i, 32'(m_data_a[i]), 32'(e[DW-1:0]));
              check("beat_last", i, 32'(m_last_a[i]), 32'(e[DW]));
              beats_seen[i]++;
              if (m_last_a[i]) last_cyc[i] = cyc;
            end
          end
        end
      end
    end
  end

  task automatic prep(input int base, input int len);
    for (int i = 0; i < 3; i++) begin
      first_cyc[i] = -1; last_cyc[i] = -1; done_cyc[i] = -1;
      done_cnt[i] = 0; busy_cnt[i] = 0; beats_seen[i] = 0; prev_stall[i] = 1'b0;
      for (int k = 0; k < len; k++)
        exp_q[i].push_back({(k == len - 1), DW'((base + k) % DEPTH)});
    end
  endtask

  task automatic run_burst(input int base, input int len, input bit toggle,
                           input bit mid_start);
    int c0;
    int n;
    prep(base, len);
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); length = (AW + 1)'(len);
    @(posedge clk); #1;
    c0 = cyc; start = 1'b0;
    if (toggle) m_ready = 1'b0;
    n = 0;
    while (n < 300 && !(done_cnt[0] > 0 && done_cnt[1] > 0 && done_cnt[2] > 0)) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (toggle) m_ready = ~m_ready;
      if (mid_start && n == 2) begin
        start = 1'b1; base_addr = AW'(100); length = (AW + 1)'(3);
      end
    end
    m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("done_pulses", i, 32'(done_cnt[i]), 32'd1);
      check("beats_left", i, 32'(exp_q[i].size()), 32'd0);
      check("beat_count", i, 32'(beats_seen[i]), 32'(len));
      if (len == 0) begin
        check("zero_done_cyc", i, 32'(done_cyc[i] - c0), 32'd0);
        check("zero_busy_cycles", i, 32'(busy_cnt[i]), 32'd1);
        check("zero_no_valid", i, 32'(first_cyc[i]), 32'hFFFFFFFF);
      end else begin
        check("first_beat_cyc", i, 32'(first_cyc[i] - c0), 32'(i + 1));
        check("done_after_last", i, 32'(done_cyc[i] - last_cyc[i]), 32'd1);
        if (!toggle)
          check("back_to_back", i, 32'(last_cyc[i] - first_cyc[i]), 32'(len - 1));
      end
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; m_ready = 1'b1;
    prep(0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("rst_addrb", i, 32'(addrb_a[i]), 32'd0);
      check("rst_m_data", i, 32'(m_data_a[i]), 32'd0);
      check("rst_m_valid", i, 32'(m_valid_a[i]), 32'd0);
      check("rst_m_last", i, 32'(m_last_a[i]), 32'd0);
      check("rst_busy", i, 32'(busy_a[i]), 32'd0);
      check("rst_done", i, 32'(done_a[i]), 32'd0);
    end
    rst_n = 1'b1;

    run_burst(5, 4, 1'b0, 1'b1);       // basic burst, start ignored while busy
    run_burst(13262, 4, 1'b0, 1'b0);   // address wrap
    run_burst(0, 8, 1'b1, 1'b0);       // ready toggling
    run_burst(0, 0, 1'b0, 1'b0);       // zero length
    run_burst(9, 1, 1'b0, 1'b0);       // single beat

    // Reset in the middle of a 10-beat burst.
    prep(20, 10);
    m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(20); length = (AW + 1)'(10);
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (n < 100 && beats_seen[1] < 3) begin
      @(negedge clk); #1;
      n++;
    end
    check("mid_reset_reached", 1, 32'(beats_seen[1]), 32'd3);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check("mid_rst_valid", i, 32'(m_valid_a[i]), 32'd0);
      check("mid_rst_busy", i, 32'(busy_a[i]), 32'd0);
      check("mid_rst_no_done", i, 32'(done_cnt[i]), 32'd0);
      exp_q[i].delete();
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_burst(40, 2, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
